// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings for the multi-cycle datapath
package datapath_pkg;
    localparam logic [3:0] OP_PASS = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3,
                           OP_DIV = 4'd4, OP_MOD = 4'd5, OP_OR = 4'd6, OP_AND = 4'd7,
                           OP_XOR = 4'd8, OP_NOT = 4'd9, OP_SHR = 4'd10, OP_SHL = 4'd11;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_IMM = 2'd2, WB_EXT = 2'd3;
    localparam logic [1:0] PC_INC = 2'd0, PC_JMP = 2'd1, PC_BZ = 2'd2, PC_HOLD = 2'd3;
    localparam logic [1:0] MEM_NONE = 2'd0, MEM_LD = 2'd1, MEM_ST = 2'd2;
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
endpackage

// File: rtl/alu_unit.sv
// alu_unit: combinational ALU with zero and carry/borrow/shifted-out flags
module alu_unit
    import datapath_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);
    logic [DW:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    // top bit of the widened difference is the borrow, set exactly when a < b
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = '1;
        carry  = 1'b0;
        case (opcode)
            OP_PASS: result = a;
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_MUL:  result = a * b;
            OP_DIV:  result = (b == '0) ? '1 : a / b;
            OP_MOD:  result = (b == '0) ? a : a % b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHR:  {result, carry} = {1'b0, a};
            OP_SHL:  {carry, result} = {a, 1'b0};
            default: result = '1;
        endcase
    end
    assign zero = (result == '0);
endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle register-file/ALU/PC datapath with handshaked memory access
module datapath_mc
    import datapath_pkg::*;
#(
    parameter int DW = 32,
    parameter int NREG = 32,
    parameter int PCW = 32,
    parameter int MAW = 10,
    localparam int RAW = $clog2(NREG)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [3:0]     opcode,
    input  logic [RAW-1:0] rd,
    input  logic [RAW-1:0] rs1,
    input  logic [RAW-1:0] rs2,
    input  logic [DW-1:0]  imm,
    input  logic           im_sel,
    input  logic           reg_we,
    input  logic [1:0]     wb_sel,
    input  logic [1:0]     pc_ctrl,
    input  logic [1:0]     mem_op,
    output logic           mem_req,
    output logic           mem_we,
    output logic [MAW-1:0] mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ready,
    input  logic [DW-1:0]  ext_in,
    output logic [PCW-1:0] pc,
    output logic           flag_zero,
    output logic           flag_carry,
    output logic           busy,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data
);
    state_t state, next;
    logic [3:0] op_q;
    logic [RAW-1:0] rd_q, rs1_q, rs2_q;
    logic [DW-1:0] imm_q, alu_q, rdata_q, a_op, b_op, rs2_val, alu_y, wb_val;
    logic ims_q, we_q, alu_c, alu_z;
    logic [1:0] wb_q, pcc_q, mop_q;
    logic [PCW-1:0] pc_next;
    logic [DW-1:0] regs [NREG];

    assign rs2_val   = (rs2_q == '0) ? '0 : regs[rs2_q];
    assign a_op      = (rs1_q == '0) ? '0 : regs[rs1_q];
    assign b_op      = ims_q ? imm_q : rs2_val;
    assign dbg_data  = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    assign instr_ready = (state == IDLE);
    assign busy      = !instr_ready;
    assign mem_req   = (state == MEM);
    assign mem_we    = mem_req && (mop_q == MEM_ST);
    assign mem_addr  = alu_q[MAW-1:0];
    assign mem_wdata = rs2_val;
    assign wb_val    = (wb_q == WB_ALU) ? alu_q : (wb_q == WB_MEM) ? rdata_q :
                       (wb_q == WB_IMM) ? imm_q : ext_in;
    // branch offset is the immediate sign-extended or truncated to the PC width
    assign pc_next   = (pcc_q == PC_JMP) ? PCW'(imm_q) : (pcc_q == PC_HOLD) ? pc :
                       (pcc_q == PC_BZ && flag_zero) ? pc + PCW'($signed(imm_q)) : pc + PCW'(1);

    alu_unit #(.DW(DW)) u_alu (
        .opcode(op_q), .a(a_op), .b(b_op), .result(alu_y), .carry(alu_c), .zero(alu_z)
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE: next = instr_valid ? EXEC : IDLE;
            EXEC: next = (mop_q == MEM_LD || mop_q == MEM_ST) ? MEM : WB;
            MEM:  next = mem_ready ? WB : MEM;
            WB:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {op_q, rd_q, rs1_q, rs2_q, imm_q, ims_q, we_q, wb_q, pcc_q, mop_q} <= '0;
            {alu_q, rdata_q, flag_zero, flag_carry} <= '0;
            pc <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (state == IDLE && instr_valid)
                {op_q, rd_q, rs1_q, rs2_q, imm_q, ims_q, we_q, wb_q, pcc_q, mop_q} <=
                    {opcode, rd, rs1, rs2, imm, im_sel, reg_we, wb_sel, pc_ctrl, mem_op};
            if (state == EXEC) {alu_q, flag_zero, flag_carry} <= {alu_y, alu_z, alu_c};
            if (state == MEM && mem_ready) rdata_q <= mem_rdata;
            if (state == WB) begin
                if (we_q && rd_q != '0) regs[rd_q] <= wb_val;
                pc <= pc_next;
            end
        end
    end
endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed and random instruction stream checked against a behavioural model
module tb_datapath_mc;
    import datapath_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic instr_valid = 1'b0, instr_ready;
    logic [3:0] opcode = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
    logic [31:0] imm = '0, mem_rdata = '0, ext_in = '0, mem_wdata, dbg_data, pc;
    logic im_sel = 1'b0, reg_we = 1'b0, mem_ready = 1'b0;
    logic [1:0] wb_sel = '0, pc_ctrl = '0, mem_op = '0;
    logic mem_req, mem_we, flag_zero, flag_carry, busy;
    logic [9:0] mem_addr;

    int n_checks = 0, n_fail = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic m_z, m_c;

    always #5 clock = ~clock;

    datapath_mc dut (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .im_sel(im_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .pc_ctrl(pc_ctrl), .mem_op(mem_op),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ext_in(ext_in), .pc(pc),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1 v = dbg_data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // {carry, result} straight from the operation table
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        case (op)
            4'd0:  return {1'b0, a};
            4'd1:  return 33'(wa + wb);
            4'd2:  return {a < b, a - b};
            4'd3:  return {1'b0, 32'(wa * wb)};
            4'd4:  return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
            4'd5:  return {1'b0, (b == 0) ? a : a % b};
            4'd6:  return {1'b0, a | b};
            4'd7:  return {1'b0, a & b};
            4'd8:  return {1'b0, a ^ b};
            4'd9:  return {1'b0, ~a};
            4'd10: return {a[0], a >> 1};
            4'd11: return {a[31], a << 1};
            default: return {1'b0, 32'hFFFF_FFFF};
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input logic ims,
                         input logic we, input logic [1:0] wb, input logic [1:0] pcc,
                         input logic [1:0] mop, input int lat, input logic [31:0] rdat);
        logic [31:0] a, b, r, wv, wd, v;
        logic [32:0] cr;
        logic c, z, is_mem;
        int edges, waited;
        a = (s1 == 0) ? 32'd0 : m_regs[s1];
        wd = (s2 == 0) ? 32'd0 : m_regs[s2];
        b = ims ? im : wd;
        cr = ref_alu(op, a, b);
        c = cr[32];
        r = cr[31:0];
        z = (r == 0);
        is_mem = (mop == MEM_LD || mop == MEM_ST);
        wv = (wb == WB_ALU) ? r : (wb == WB_MEM) ? rdat : (wb == WB_IMM) ? im : ext_in;
        @(posedge clock);
        #1 check("instr_ready", instr_ready, 1);
        {opcode, rd, rs1, rs2, imm, im_sel, reg_we, wb_sel, pc_ctrl, mem_op} =
            {op, d, s1, s2, im, ims, we, wb, pcc, mop};
        instr_valid = 1'b1;
        @(posedge clock);
        #1 check("busy", busy, 1);
        edges = 0;
        waited = 0;
        while (!instr_ready && edges < 200) begin
            // junk fields with valid high while busy must be ignored
            instr_valid = 1'($urandom);
            {opcode, rd, rs1, rs2, imm} = {4'($urandom), 15'($urandom), 32'($urandom)};
            {im_sel, reg_we, wb_sel, pc_ctrl, mem_op} = 8'($urandom);
            if (mem_req) begin
                check("mem_we", mem_we, mop == MEM_ST);
                check("mem_addr", mem_addr, r[9:0]);
                check("mem_wdata", mem_wdata, wd);
                mem_ready = (waited >= lat);
                mem_rdata = mem_ready ? rdat : $urandom;
                waited++;
            end
            @(posedge clock);
            #1 mem_ready = 1'b0;
            edges++;
        end
        instr_valid = 1'b0;
        check("latency", edges, is_mem ? lat + 3 : 2);
        if (we && d != 0) m_regs[d] = wv;
        m_pc = (pcc == PC_INC) ? m_pc + 1 : (pcc == PC_JMP) ? im :
               (pcc == PC_BZ) ? (z ? m_pc + im : m_pc + 1) : m_pc;
        m_z = z;
        m_c = c;
        check("pc", pc, m_pc);
        check("flag_zero", flag_zero, m_z);
        check("flag_carry", flag_carry, m_c);
        peek(d, v);
        check("reg_rd", v, m_regs[d]);
    endtask

    logic [31:0] v;
    logic [1:0] r_mop, r_wb;
    initial begin
        model_reset();
        ext_in = $urandom;
        #3 reset_n = 1'b0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_flags", {flag_zero, flag_carry}, 0);
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), v);
            check("rst_reg", v, 0);
        end
        #2 reset_n = 1'b1;

        issue(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        peek(1, v);
        check("r1_eq_5", v, 5);
        check("pc_eq_1", pc, 1);
        issue(OP_SUB, 5'd2, 5'd1, 5'd1, 32'd4, 0, 1, WB_ALU, PC_BZ, MEM_NONE, 0, 0);
        check("bz_taken_pc", pc, 5);
        check("bz_zero", flag_zero, 1);
        issue(OP_SUB, 5'd2, 5'd1, 5'd0, 32'd4, 0, 1, WB_ALU, PC_BZ, MEM_NONE, 0, 0);
        check("bz_not_taken_pc", pc, 6);
        check("sub_no_borrow", flag_carry, 0);
        issue(OP_ADD, 5'd0, 5'd1, 5'd1, 32'd3, 1, 0, WB_ALU, PC_INC, MEM_ST, 3, 0);
        issue(OP_ADD, 5'd3, 5'd1, 5'd0, 32'd3, 1, 1, WB_MEM, PC_INC, MEM_LD, 2, 32'hA5A5_A5A5);
        peek(3, v);
        check("load_r3", v, 32'hA5A5_A5A5);
        issue(OP_ADD, 5'd4, 5'd0, 5'd0, 32'd7, 1, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        issue(OP_DIV, 5'd5, 5'd4, 5'd0, 32'd0, 0, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        peek(5, v);
        check("div0", v, 32'hFFFF_FFFF);
        issue(OP_MOD, 5'd6, 5'd4, 5'd0, 32'd0, 0, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        peek(6, v);
        check("mod0", v, 7);
        issue(OP_ADD, 5'd7, 5'd5, 5'd0, 32'd1, 1, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        check("wrap_carry", flag_carry, 1);
        check("wrap_zero", flag_zero, 1);
        issue(OP_PASS, 5'd0, 5'd1, 5'd0, 32'd9, 1, 1, WB_IMM, PC_JMP, MEM_NONE, 0, 0);
        peek(0, v);
        check("r0_zero", v, 0);
        check("jump_pc", pc, 9);

        for (int n = 0; n < 80; n++) begin
            r_mop = 2'($urandom);
            r_wb = 2'($urandom);
            if (r_wb == WB_MEM && !(r_mop == MEM_LD || r_mop == MEM_ST)) r_wb = WB_ALU;
            ext_in = $urandom;
            issue(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15), 1'($urandom),
                  1'($urandom), r_wb, 2'($urandom), r_mop, $urandom_range(0, 4), $urandom);
        end

        @(posedge clock);
        #1 {opcode, rd, rs1, rs2, imm, im_sel, reg_we, wb_sel, pc_ctrl, mem_op} =
            {OP_ADD, 5'd8, 5'd0, 5'd0, 32'd16, 1'b1, 1'b1, WB_MEM, PC_INC, MEM_LD};
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(posedge clock);
        #1 check("abort_mem_req_before", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        peek(8, v);
        check("abort_r8", v, 0);
        reset_n = 1'b1;
        model_reset();
        issue(OP_ADD, 5'd9, 5'd8, 5'd0, 32'd1, 1, 1, WB_ALU, PC_INC, MEM_NONE, 0, 0);
        peek(9, v);
        check("after_abort_r9", v, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
